// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port word RAM: fetch (I) and load/store (D),
// alternating priority on contention, read-modify-write for partial stores.
module ram_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDR_WIDTH-1:0]   d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   input  logic [DATA_WIDTH/8-1:0] d_be,
   output logic                    d_gnt,
   output logic                    d_rvalid,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic [ADDR_WIDTH-1:0]   ram_address,
   output logic [DATA_WIDTH-1:0]   ram_data_in,
   output logic                    ram_write,
   output logic                    ram_read,
   input  logic [DATA_WIDTH-1:0]   ram_data_out,
   output logic                    dbg_state
);
   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic {IDLE = 1'b0, RMW = 1'b1} state_t;

   state_t                r_state;
   logic                  r_last_d;
   logic                  r_pend_i;
   logic                  r_pend_d;
   logic [ADDR_WIDTH-1:0] r_rmw_addr;
   logic [DATA_WIDTH-1:0] r_rmw_wdata;
   logic [NB-1:0]         r_rmw_be;

   logic                  w_idle, w_rmw, w_pick_i, w_pick_d;
   logic                  w_be_full, w_be_none;
   logic                  w_load, w_full_st, w_none_st, w_part_st;
   logic [DATA_WIDTH-1:0] w_merged;

   // Handshake: a requester holds req and its fields stable until gnt; gnt is the
   // acceptance (or completion, for stores) cycle, and rvalid follows a read gnt by one cycle.
   assign w_idle    = (r_state == IDLE) && !rst;
   assign w_rmw     = (r_state == RMW) && !rst;
   assign w_pick_i  = w_idle && if_req && (!d_req || r_last_d);
   assign w_pick_d  = w_idle && d_req && !w_pick_i;
   assign w_be_full = &d_be;
   assign w_be_none = ~|d_be;
   assign w_load    = w_pick_d && !d_we;
   assign w_full_st = w_pick_d && d_we && w_be_full;
   assign w_none_st = w_pick_d && d_we && w_be_none;
   assign w_part_st = w_pick_d && d_we && !w_be_full && !w_be_none;
   assign dbg_state = (r_state == RMW);

   always_comb begin
      w_merged = '0;
      for (int b = 0; b < NB; b++) begin
         w_merged[8*b +: 8] = r_rmw_be[b] ? r_rmw_wdata[8*b +: 8] : ram_data_out[8*b +: 8];
      end
   end

   always_comb begin
      if_gnt      = w_pick_i;
      d_gnt       = w_load || w_full_st || w_none_st || w_rmw;
      ram_read    = w_pick_i || w_load || w_part_st;
      ram_write   = w_full_st || w_rmw;
      ram_address = '0;
      ram_data_in = '0;
      if (w_pick_i) begin
         ram_address = if_addr;
      end else if (w_load || w_full_st || w_part_st) begin
         ram_address = d_addr;
      end else if (w_rmw) begin
         ram_address = r_rmw_addr;
      end
      if (w_full_st) begin
         ram_data_in = d_wdata;
      end else if (w_rmw) begin
         ram_data_in = w_merged;
      end
      if_rvalid = r_pend_i && !rst;
      d_rvalid  = r_pend_d && !rst;
      if_rdata  = if_rvalid ? ram_data_out : '0;
      d_rdata   = d_rvalid ? ram_data_out : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_last_d    <= 1'b1;
         r_pend_i    <= 1'b0;
         r_pend_d    <= 1'b0;
         r_rmw_addr  <= '0;
         r_rmw_wdata <= '0;
         r_rmw_be    <= '0;
      end else begin
         r_pend_i <= w_pick_i;
         r_pend_d <= w_load;
         if (w_pick_i) begin
            r_last_d <= 1'b0;
         end else if (w_pick_d) begin
            r_last_d <= 1'b1;
         end
         if (r_state == IDLE) begin
            if (w_part_st) begin
               r_state     <= RMW;
               r_rmw_addr  <= d_addr;
               r_rmw_wdata <= d_wdata;
               r_rmw_be    <= d_be;
            end
         end else begin
            r_state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-output RAM and
// per-port expected read-data queues.
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        preload;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic [31:0] ram_address, ram_data_in, ram_data_out;
   logic        ram_write, ram_read;
   logic        dbg_state;

   logic [31:0] mem [16];
   logic [31:0] exp_q_i[$];
   logic [31:0] exp_q_d[$];
   int          checks = 0;
   int          failures = 0;
   logic        prev_gnt_i = 1'b0;
   logic        prev_load_d = 1'b0;
   logic        exp_last_d;

   always #5 clk = ~clk;

   ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_address(ram_address), .ram_data_in(ram_data_in),
      .ram_write(ram_write), .ram_read(ram_read), .ram_data_out(ram_data_out),
      .dbg_state(dbg_state)
   );

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[5] <= 32'hDEADBEEF;
         mem[7] <= 32'hCAFEF00D;
         ram_data_out <= 32'h0;
      end else begin
         if (ram_write) mem[ram_address[3:0]] <= ram_data_in;
         if (ram_read) ram_data_out <= mem[ram_address[3:0]];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Read-data scoreboard and per-cycle protocol checks.
   always @(negedge clk) begin
      chk("if_rvalid_timing", {31'b0, if_rvalid}, {31'b0, prev_gnt_i & ~rst});
      chk("d_rvalid_timing", {31'b0, d_rvalid}, {31'b0, prev_load_d & ~rst});
      if (if_rvalid) begin
         if (exp_q_i.size() == 0) chk("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'h0);
         else chk("if_rdata", if_rdata, exp_q_i.pop_front());
      end else begin
         chk("if_rdata_zero", if_rdata, 32'h0);
      end
      if (d_rvalid) begin
         if (exp_q_d.size() == 0) chk("d_rvalid_unexpected", {31'b0, d_rvalid}, 32'h0);
         else chk("d_rdata", d_rdata, exp_q_d.pop_front());
      end else begin
         chk("d_rdata_zero", d_rdata, 32'h0);
      end
      chk("single_gnt", {31'b0, if_gnt & d_gnt}, 32'h0);
      prev_gnt_i  = if_gnt;
      prev_load_d = d_gnt & ~d_we;
   end

   initial begin
      rst = 1'b1; preload = 1'b1;
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7; d_wdata = 32'h0; d_be = 4'h0;
      exp_last_d = 1'b1;
      @(negedge clk);
      chk("rst_if_gnt", {31'b0, if_gnt}, 32'h0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("rst_ram_read", {31'b0, ram_read}, 32'h0);
      chk("rst_ram_write", {31'b0, ram_write}, 32'h0);
      next_cycle();
      preload = 1'b0; if_req = 1'b0; d_req = 1'b0;
      next_cycle();
      rst = 1'b0;

      // single fetch
      next_cycle();
      if_req = 1'b1; if_addr = 32'd5;
      @(negedge clk);
      chk("fetch_gnt", {31'b0, if_gnt}, 32'h1);
      chk("fetch_ram_read", {31'b0, ram_read}, 32'h1);
      chk("fetch_addr", ram_address, 32'd5);
      exp_q_i.push_back(32'hDEADBEEF);
      exp_last_d = 1'b0;
      next_cycle();
      if_req = 1'b0;

      // contention: grants alternate
      next_cycle();
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("alt_if_gnt", {31'b0, if_gnt}, {31'b0, exp_last_d});
         chk("alt_d_gnt", {31'b0, d_gnt}, {31'b0, ~exp_last_d});
         if (exp_last_d) exp_q_i.push_back(32'hDEADBEEF);
         else exp_q_d.push_back(32'hCAFEF00D);
         exp_last_d = ~exp_last_d;
         next_cycle();
      end
      if_req = 1'b0; d_req = 1'b0;

      // full store then load back
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd3; d_wdata = 32'h11223344; d_be = 4'hF;
      @(negedge clk);
      chk("full_st_gnt", {31'b0, d_gnt}, 32'h1);
      chk("full_st_write", {31'b0, ram_write}, 32'h1);
      chk("full_st_read", {31'b0, ram_read}, 32'h0);
      chk("full_st_data", ram_data_in, 32'h11223344);
      chk("full_st_addr", ram_address, 32'd3);
      exp_last_d = 1'b1;
      next_cycle();
      d_we = 1'b0;
      @(negedge clk);
      chk("load3_gnt", {31'b0, d_gnt}, 32'h1);
      exp_q_d.push_back(32'h11223344);
      next_cycle();
      d_req = 1'b0;

      // fetch so that D has priority, then partial store with fetch waiting
      next_cycle();
      if_req = 1'b1; if_addr = 32'd5;
      @(negedge clk);
      chk("pre_rmw_fetch_gnt", {31'b0, if_gnt}, 32'h1);
      exp_q_i.push_back(32'hDEADBEEF);
      exp_last_d = 1'b0;
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd3; d_wdata = 32'hAABBCCDD; d_be = 4'b0101;
      @(negedge clk);
      chk("rmw_n_d_gnt", {31'b0, d_gnt}, 32'h0);
      chk("rmw_n_if_gnt", {31'b0, if_gnt}, 32'h0);
      chk("rmw_n_read", {31'b0, ram_read}, 32'h1);
      chk("rmw_n_addr", ram_address, 32'd3);
      next_cycle();
      @(negedge clk);
      chk("rmw_n1_state", {31'b0, dbg_state}, 32'h1);
      chk("rmw_n1_d_gnt", {31'b0, d_gnt}, 32'h1);
      chk("rmw_n1_if_gnt", {31'b0, if_gnt}, 32'h0);
      chk("rmw_n1_write", {31'b0, ram_write}, 32'h1);
      chk("rmw_n1_data", ram_data_in, 32'h11BB33DD);
      chk("rmw_n1_addr", ram_address, 32'd3);
      next_cycle();
      d_req = 1'b0;
      @(negedge clk);
      chk("rmw_n2_if_gnt", {31'b0, if_gnt}, 32'h1);
      exp_q_i.push_back(32'hDEADBEEF);
      next_cycle();
      if_req = 1'b0;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd3;
      @(negedge clk);
      chk("load_rmw_gnt", {31'b0, d_gnt}, 32'h1);
      exp_q_d.push_back(32'h11BB33DD);
      next_cycle();

      // empty byte-enable store
      d_we = 1'b1; d_wdata = 32'hFFFFFFFF; d_be = 4'h0;
      @(negedge clk);
      chk("be0_gnt", {31'b0, d_gnt}, 32'h1);
      chk("be0_read", {31'b0, ram_read}, 32'h0);
      chk("be0_write", {31'b0, ram_write}, 32'h0);
      next_cycle();
      d_we = 1'b0;
      @(negedge clk);
      exp_q_d.push_back(32'h11BB33DD);
      next_cycle();
      d_req = 1'b0;

      // reset during the RMW cycle
      next_cycle();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd7; d_wdata = 32'h0; d_be = 4'b0011;
      @(negedge clk);
      chk("rst_rmw_n_read", {31'b0, ram_read}, 32'h1);
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rmw_write", {31'b0, ram_write}, 32'h0);
      chk("rst_rmw_d_gnt", {31'b0, d_gnt}, 32'h0);
      next_cycle();
      rst = 1'b0; d_req = 1'b0;
      exp_last_d = 1'b1;
      next_cycle();
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd7;
      @(negedge clk);
      chk("post_rst_if_gnt", {31'b0, if_gnt}, 32'h1);
      chk("post_rst_d_gnt", {31'b0, d_gnt}, 32'h0);
      exp_q_i.push_back(32'hDEADBEEF);
      next_cycle();
      if_req = 1'b0;
      @(negedge clk);
      chk("post_rst_load_gnt", {31'b0, d_gnt}, 32'h1);
      exp_q_d.push_back(32'hCAFEF00D);
      next_cycle();
      d_req = 1'b0;
      next_cycle();
      next_cycle();

      chk("exp_q_i_drained", exp_q_i.size(), 32'h0);
      chk("exp_q_d_drained", exp_q_d.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
